// File: rtl/coeff_bank_server.sv
// Coefficient bank server: streams a 1024-word load into eight banks of packed
// tap pairs and serves every bank from one registered, shared read address.
module coeff_bank_server #(
    parameter int COEFF_W = 18,
    parameter int ADDR_W  = 6,
    parameter int NFILT   = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load_start,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [COEFF_W-1:0]     wr_data,
    output logic                   load_busy,
    output logic                   load_done,
    output logic                   coeff_valid,
    input  logic [ADDR_W-1:0]      coeffaddress,
    output logic [2*COEFF_W-1:0]   coeff0,
    output logic [2*COEFF_W-1:0]   coeff1,
    output logic [2*COEFF_W-1:0]   coeff2,
    output logic [2*COEFF_W-1:0]   coeff3,
    output logic [2*COEFF_W-1:0]   coeff4,
    output logic [2*COEFF_W-1:0]   coeff5,
    output logic [2*COEFF_W-1:0]   coeff6,
    output logic [2*COEFF_W-1:0]   coeff7
);

    localparam int ENTRY_W = 2 * COEFF_W;
    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int BANK_W  = $clog2(NFILT);
    localparam int TAP_W   = ADDR_W + 1;
    localparam int CNT_W   = BANK_W + TAP_W;

    typedef enum logic {
        S_IDLE,
        S_LOAD
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [COEFF_W-1:0]   hold_q, hold_d;
    logic                 load_done_q, load_done_d;
    logic                 coeff_valid_q, coeff_valid_d;
    logic [ENTRY_W-1:0]   coeff_q [NFILT];
    logic [ENTRY_W-1:0]   coeff_d [NFILT];

    // Coefficient storage; intentionally not reset.
    logic [ENTRY_W-1:0]   mem [NFILT][DEPTH];

    logic                 accept;
    logic                 last_word;
    logic                 mem_we;
    logic [BANK_W-1:0]    wr_bank;
    logic [ADDR_W-1:0]    wr_entry;

    assign accept    = wr_valid && wr_ready;
    assign last_word = &count_q;
    assign wr_bank   = count_q[CNT_W-1:TAP_W];
    assign wr_entry  = count_q[TAP_W-1:1];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (load_start) state_d = S_LOAD;
            S_LOAD:  if (accept && last_word) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ready  = 1'b0;
        load_busy = 1'b0;
        if (state_q == S_LOAD) begin
            wr_ready  = 1'b1;
            load_busy = 1'b1;
        end
    end

    // Even taps wait in hold_q; the odd tap completes the pair and commits it.
    always_comb begin
        count_d       = count_q;
        hold_d        = hold_q;
        load_done_d   = 1'b0;
        coeff_valid_d = coeff_valid_q;
        mem_we        = 1'b0;
        if (state_q == S_IDLE && load_start) begin
            count_d       = '0;
            coeff_valid_d = 1'b0;
        end
        if (accept) begin
            count_d = count_q + CNT_W'(1);
            if (!count_q[0]) begin
                hold_d = wr_data;
            end else begin
                mem_we = 1'b1;
            end
            if (last_word) begin
                load_done_d   = 1'b1;
                coeff_valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        for (int unsigned n = 0; n < NFILT; n++) begin
            coeff_d[BANK_W'(n)] = mem[BANK_W'(n)][coeffaddress];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q       <= '0;
            hold_q        <= '0;
            load_done_q   <= 1'b0;
            coeff_valid_q <= 1'b0;
            coeff_q       <= '{default: '0};
        end else begin
            count_q       <= count_d;
            hold_q        <= hold_d;
            load_done_q   <= load_done_d;
            coeff_valid_q <= coeff_valid_d;
            coeff_q       <= coeff_d;
        end
    end

    // Read registers sample before this write lands, giving read-before-write.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[wr_bank][wr_entry] <= {wr_data, hold_q};
        end
    end

    assign load_done   = load_done_q;
    assign coeff_valid = coeff_valid_q;
    assign coeff0      = coeff_q[0];
    assign coeff1      = coeff_q[1];
    assign coeff2      = coeff_q[2];
    assign coeff3      = coeff_q[3];
    assign coeff4      = coeff_q[4];
    assign coeff5      = coeff_q[5];
    assign coeff6      = coeff_q[6];
    assign coeff7      = coeff_q[7];

endmodule

// File: doc/coeff_bank_server.md
COEFF_BANK_SERVER -- requirements
Module: coeff_bank_server

Interface
REQ-001 Parameter COEFF_W, default 18: coefficient word width in bits; packed entry width is 2*COEFF_W (36).
REQ-002 Parameter ADDR_W, default 6: read address width; each bank holds 2**ADDR_W (64) packed entries.
REQ-003 Parameter NFILT, default 8: number of coefficient banks; fixed at 8 by the port list.
REQ-004 Reset is reset, synchronous, active-high; the clock is clock.
REQ-005 clock  input  1  master clock, rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 load_start  input  1  one-cycle pulse that begins a full coefficient load.
REQ-008 wr_valid  input  1  wr_data carries a coefficient word.
REQ-009 wr_ready  output  1  block accepts a word this cycle.
REQ-010 wr_data  input  18  signed coefficient word.
REQ-011 load_busy  output  1  load in progress.
REQ-012 load_done  output  1  one-cycle pulse when the load completes.
REQ-013 coeff_valid  output  1  all banks hold a complete load.
REQ-014 coeffaddress  input  6  read address, shared by all banks.
REQ-015 coeff0..coeff7  output  36 each  packed entry of banks 0..7 at the registered address.

Function
REQ-016 The FSM SHALL have two states: IDLE and LOAD.
REQ-017 IDLE -> LOAD on load_start; word counter cleared to 0; coeff_valid cleared in the same edge.
REQ-018 In LOAD: wr_ready=1 and load_busy=1. In IDLE: both 0.
REQ-019 A word is accepted only when wr_valid and wr_ready are both 1; wr_valid in IDLE is ignored and writes nothing.
REQ-020 Load order is 1024 words: bank 0 taps 0..127, then bank 1 taps 0..127, through bank 7.
REQ-021 Word counter is 10 bits: bits [9:7] = bank, [6:0] = tap.
REQ-022 Even tap 2k SHALL be held in a holding register.
REQ-023 On odd tap 2k+1, write entry k of the current bank as {tap 2k+1 in [35:18], tap 2k in [17:0]}, in the accepting cycle.
REQ-024 When word 1023 is accepted: go to IDLE; pulse load_done for one cycle on the next cycle; set coeff_valid=1 on the next cycle and hold it until the next load_start or reset.
REQ-025 load_start while in LOAD SHALL be ignored; the counter continues.
REQ-026 Gaps on wr_valid SHALL stall the counter without data loss.
REQ-027 Read port: coeffN SHALL equal bank N entry at coeffaddress sampled on the previous rising edge (1-cycle latency), in every state.
REQ-028 Read during write of the same entry SHALL return the old contents (read-before-write).
REQ-029 Coefficient data is passed through bit-exact; no arithmetic is performed on it.

Reset
REQ-030 On reset: state IDLE; counter and holding register 0; wr_ready, load_busy, load_done and coeff_valid 0; coeff0..7 registers 0.
REQ-031 Memory contents SHALL NOT be reset; they are undefined until first loaded.
REQ-032 Reset mid-load SHALL abort the load; a following load_start restarts at word 0.

Verification
REQ-033 Reset -> wr_ready=0, load_busy=0, load_done=0, coeff_valid=0, coeff0..7=0.
REQ-034 load_start, then words n=0..1023 with value n, back-to-back -> load_done high exactly one cycle after the 1024th accept. Then coeffaddress=5 -> next cycle coeff3={18'd395,18'd394} and coeff0={18'd11,18'd10}.
REQ-035 Same load with random wr_valid gaps, plus wr_valid=1 pulses in IDLE before load_start -> identical memory contents; IDLE pulses write nothing.
REQ-036 Reset after 300 accepted words -> busy=0, ready=0, coeff_valid=0. Then full load of value 1023-n -> coeff7 at address 63 = {18'd0,18'd1}.
REQ-037 load_start pulse at word 500 -> ignored; load_done after word 1023; contents match the single-load reference.
REQ-038 Load A complete, then load B with coeffaddress held at the entry being written -> coeffN shows the A value in the write cycle and the B value one cycle later.
